conv_mac_3x3: RTL

Pipelined 3x3 convolution MAC stage. It sits directly downstream of the 3x3 line-buffer/window generator and consumes its packed, zero-padded 9-pixel window plus window valid. Each valid window is multiplied by a programmable signed kernel, summed with a bias, then rounded, shifted, optionally ReLU'd and saturated. The block emits one output pixel per window, tagged with raster position and end-of-line/end-of-frame flags.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_requant.sv | 45 ++++
 rtl/conv_mac_3x3.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and width helpers for the 3x3 convolution MAC.
package conv_pkg;

   localparam int unsigned TAP_COUNT       = 9;
   localparam int unsigned COEF_ADDR_WIDTH = 4;
   localparam logic [COEF_ADDR_WIDTH-1:0] BIAS_ADDR = 4'd9;

   // Tap index k = 3*row + col, row 0 = top, col 0 = left.
   localparam int unsigned TAP_TL = 0;
   localparam int unsigned TAP_TC = 1;
   localparam int unsigned TAP_TR = 2;
   localparam int unsigned TAP_ML = 3;
   localparam int unsigned TAP_MC = 4;
   localparam int unsigned TAP_MR = 5;
   localparam int unsigned TAP_BL = 6;
   localparam int unsigned TAP_BC = 7;
   localparam int unsigned TAP_BR = 8;

   typedef enum logic {
      ST_UNLOADED = 1'b0,
      ST_ACTIVE   = 1'b1
   } coef_state_e;

   // Signed product of a zero-extended pixel and a signed coefficient.
   function automatic int unsigned prod_width(input int unsigned data_width,
                                              input int unsigned coef_width);
      return data_width + coef_width + 1;
   endfunction

   // Four guard bits cover nine products plus the bias without overflow.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned coef_width);
      return prod_width(data_width, coef_width) + 4;
   endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: round-half-up, arithmetic shift, then ReLU/unsigned or signed saturation.
module conv_requant
   import conv_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = 21,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned SHIFT     = 4,
   parameter bit          RELU_EN   = 1'b1
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic        [OUT_WIDTH-1:0] pix
);

   // One extra bit so adding the rounding constant can never wrap.
   localparam int unsigned RW = ACC_WIDTH + 1;

   localparam logic signed [RW-1:0] RND  = RW'((64'(1) << SHIFT) >> 1);
   localparam logic signed [RW-1:0] UMAX = RW'((64'(1) << OUT_WIDTH) - 64'(1));
   localparam logic signed [RW-1:0] SMAX = RW'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
   localparam logic signed [RW-1:0] SMIN = ~SMAX;

   logic signed [RW-1:0] sum_c;
   logic signed [RW-1:0] shr_c;

   // Round, shift and clamp to the output range.
   always_comb begin
      sum_c = {acc[ACC_WIDTH-1], acc} + RND;
      shr_c = sum_c >>> SHIFT;
      pix   = shr_c[OUT_WIDTH-1:0];
      if (RELU_EN) begin
         if (shr_c[RW-1]) begin
            pix = '0;
         end else if (shr_c > UMAX) begin
            pix = '1;
         end
      end else begin
         if (shr_c > SMAX) begin
            pix = SMAX[OUT_WIDTH-1:0];
         end else if (shr_c < SMIN) begin
            pix = SMIN[OUT_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/conv_mac_3x3.sv
// Pipelined 3x3 convolution MAC: products, row sums, total+bias, requantize; tags raster position.
module conv_mac_3x3
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned COEF_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned SHIFT      = 4,
   parameter bit          RELU_EN    = 1'b1,
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64,
   localparam int unsigned X_WIDTH   = $clog2(IMG_WIDTH),
   localparam int unsigned Y_WIDTH   = $clog2(IMG_HEIGHT)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [TAP_COUNT*DATA_WIDTH-1:0] window_in,
   input  logic                            window_valid,
   input  logic                            coef_wr_en,
   input  logic [COEF_ADDR_WIDTH-1:0]      coef_wr_addr,
   input  logic [COEF_WIDTH-1:0]           coef_wr_data,
   input  logic                            coef_commit,
   output logic [OUT_WIDTH-1:0]            pix_out,
   output logic                            pix_valid,
   output logic [X_WIDTH-1:0]              out_x,
   output logic [Y_WIDTH-1:0]              out_y,
   output logic                            eol,
   output logic                            eof,
   output logic                            coef_ready,
   output logic                            err_nocoef
);

   localparam int unsigned P_WIDTH   = prod_width(DATA_WIDTH, COEF_WIDTH);
   localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH);
   localparam int unsigned BANK_SIZE = TAP_COUNT + 1;
   localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_WIDTH - 1);
   localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_HEIGHT - 1);

   typedef logic signed [COEF_WIDTH-1:0] coef_t;
   typedef logic signed [P_WIDTH-1:0]    prod_t;
   typedef logic signed [ACC_WIDTH-1:0]  acc_t;

   coef_state_e state_q;
   coef_state_e state_d;
   logic        accept_c;
   logic        drop_c;

   // Bank entries 0..8 are taps, entry 9 is the bias.
   coef_t shadow_q [BANK_SIZE];
   coef_t active_q [BANK_SIZE];

   prod_t prod_c   [TAP_COUNT];
   prod_t prod_q   [TAP_COUNT];
   coef_t bias1_q;
   acc_t  row_q    [3];
   coef_t bias2_q;
   acc_t  acc_q;
   logic  v1_q;
   logic  v2_q;
   logic  v3_q;

   logic [OUT_WIDTH-1:0] requant_c;

   function automatic acc_t sx_prod(input prod_t p);
      return {{(ACC_WIDTH - P_WIDTH){p[P_WIDTH-1]}}, p};
   endfunction

   function automatic acc_t sx_coef(input coef_t c);
      return {{(ACC_WIDTH - COEF_WIDTH){c[COEF_WIDTH-1]}}, c};
   endfunction

   // Coefficient-load FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNLOADED;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus window accept/drop decode.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      drop_c   = 1'b0;
      case (state_q)
         ST_UNLOADED: begin
            drop_c = window_valid;
            if (coef_commit) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            accept_c = window_valid;
         end
         default: begin
            state_d = ST_UNLOADED;
         end
      endcase
   end

   assign coef_ready = (state_q == ST_ACTIVE);

   // Shadow writes and commits; a same-cycle write is not part of the commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < BANK_SIZE; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         if (coef_commit) begin
            for (int unsigned k = 0; k < BANK_SIZE; k++) begin
               active_q[k] <= shadow_q[k];
            end
         end
         if (coef_wr_en) begin
            for (int unsigned k = 0; k < BANK_SIZE; k++) begin
               if (coef_wr_addr == COEF_ADDR_WIDTH'(k)) begin
                  shadow_q[k] <= coef_wr_data;
               end
            end
         end
      end
   end

   // Sticky flag for windows that arrived before any kernel was committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_nocoef <= 1'b0;
      end else if (drop_c) begin
         err_nocoef <= 1'b1;
      end
   end

   // Per-tap products of zero-extended pixel and signed coefficient.
   for (genvar k = 0; k < TAP_COUNT; k++) begin : g_tap
      prod_t px_ext;
      prod_t cf_ext;
      assign px_ext    = {{(P_WIDTH - DATA_WIDTH){1'b0}}, window_in[k*DATA_WIDTH +: DATA_WIDTH]};
      assign cf_ext    = {{(P_WIDTH - COEF_WIDTH){active_q[k][COEF_WIDTH-1]}}, active_q[k]};
      assign prod_c[k] = px_ext * cf_ext;
   end

   // Stages 1-3: products, row sums, total plus bias.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         bias1_q <= '0;
         bias2_q <= '0;
         acc_q   <= '0;
         for (int unsigned k = 0; k < TAP_COUNT; k++) begin
            prod_q[k] <= '0;
         end
         for (int unsigned r = 0; r < 3; r++) begin
            row_q[r] <= '0;
         end
      end else begin
         v1_q <= accept_c;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (accept_c) begin
            prod_q  <= prod_c;
            bias1_q <= active_q[BIAS_ADDR];
         end
         if (v1_q) begin
            row_q[0] <= sx_prod(prod_q[TAP_TL]) + sx_prod(prod_q[TAP_TC]) + sx_prod(prod_q[TAP_TR]);
            row_q[1] <= sx_prod(prod_q[TAP_ML]) + sx_prod(prod_q[TAP_MC]) + sx_prod(prod_q[TAP_MR]);
            row_q[2] <= sx_prod(prod_q[TAP_BL]) + sx_prod(prod_q[TAP_BC]) + sx_prod(prod_q[TAP_BR]);
            bias2_q  <= bias1_q;
         end
         if (v2_q) begin
            acc_q <= row_q[0] + row_q[1] + row_q[2] + sx_coef(bias2_q);
         end
      end
   end

   conv_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT),
      .RELU_EN   (RELU_EN)
   ) u_requant (
      .acc (acc_q),
      .pix (requant_c)
   );

   // Stage 4 output register and raster position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_out   <= '0;
         pix_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         pix_valid <= v3_q;
         if (v3_q) begin
            pix_out <= requant_c;
         end
         if (pix_valid) begin
            if (out_x == X_LAST) begin
               out_x <= '0;
               out_y <= (out_y == Y_LAST) ? '0 : out_y + Y_WIDTH'(1);
            end else begin
               out_x <= out_x + X_WIDTH'(1);
            end
         end
      end
   end

   assign eol = pix_valid && (out_x == X_LAST);
   assign eof = eol && (out_y == Y_LAST);

endmodule
